// File: rtl/vc16_fetch_pkg.sv
// vc16_fetch_pkg: shared state, entry and constant definitions for the vc16 fetch queue.
package vc16_fetch_pkg;
    localparam int          FETCH_RV       = 32;
    localparam logic [15:0] FETCH_TRAP_INS = 16'h0000;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} fetch_state_t;

    typedef struct packed {
        logic [FETCH_RV-1:0] pc;
        logic [15:0]         ins;
        logic                fault;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry ring buffer with wrapping pointers and occupancy count.
// A clear in the same cycle as a push wins, so the pushed word is dropped.
module fetch_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + AW'(i_push);
            r_head  <= r_head + AW'(i_pop);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_tail] <= i_data;
    end

    assign o_data  = r_mem[r_head];
    assign o_empty = r_count == '0;
    assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: 16-bit instruction prefetch queue with one outstanding memory request.
module fetch_queue
    import vc16_fetch_pkg::*;
#(
    parameter int            RV       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [RV-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
`ifdef FETCH_FAULT_EN
    input  logic          mem_fault,
`endif
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    input  logic          stall,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          idone,
    output logic          fetch_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_FAULT_EN
    localparam int W = RV + 17;
`else
    localparam int W = RV + 16;
`endif

    fetch_state_t  r_state;
    logic [RV-1:0] r_fetch_pc;
    logic [W-1:0]  w_push_data;
    logic [W-1:0]  w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic [RV-1:0] w_pc_inc;
    logic          w_empty;
    logic          w_push;
    logic          w_fault;
    logic          w_head_fault;

    assign w_push       = r_state == REQ && mem_ack && !redirect;
    assign idone        = !w_empty && !stall && !redirect;
    assign w_count_next = w_count + CW'(w_push) - CW'(idone);
    assign w_pc_inc     = r_fetch_pc + RV'(2);

`ifdef FETCH_FAULT_EN
    assign w_fault      = mem_fault;
    assign w_push_data  = {r_fetch_pc, mem_rdata, mem_fault};
    assign w_head_fault = w_head[0];
    assign ins          = w_head_fault ? FETCH_TRAP_INS : w_head[16:1];
`else
    assign w_fault      = 1'b0;
    assign w_push_data  = {r_fetch_pc, mem_rdata};
    assign w_head_fault = 1'b0;
    assign ins          = w_head[15:0];
`endif
    assign ins_pc      = w_head[W-1 -: RV];
    assign fetch_fault = idone && w_head_fault;

    fetch_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (idone),
        .i_clear (redirect),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // mem_req is high exactly in REQ and DISCARD, so it doubles as "request outstanding"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc & ~RV'(1);
            if (mem_req && mem_ack) begin
                r_state <= IDLE;
                mem_req <= 1'b0;
            end else begin
                r_state <= mem_req ? DISCARD : IDLE;
            end
        end else begin
            case (r_state)
                IDLE: if (w_count < CW'(DEPTH)) begin
                    r_state  <= REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= r_fetch_pc;
                end
                REQ: if (mem_ack) begin
                    if (w_fault) begin
                        r_state <= HALT;
                        mem_req <= 1'b0;
                    end else begin
                        r_fetch_pc <= w_pc_inc;
                        mem_addr   <= w_pc_inc;
                        mem_req    <= w_count_next < CW'(DEPTH);
                        r_state    <= w_count_next < CW'(DEPTH) ? REQ : IDLE;
                    end
                end
                DISCARD: if (mem_ack) begin
                    r_state <= IDLE;
                    mem_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: memory responder pushes expected entries on each ack; issue monitor pops and compares.
`timescale 1ns/1ps
module tb_fetch_queue;
    import vc16_fetch_pkg::*;

    logic        clk = 0, reset = 0, mem_ack = 0, redirect = 0, stall = 0;
    logic        mem_req, idone, fetch_fault;
    logic [31:0] mem_addr, ins_pc, redirect_pc = 0;
    logic [15:0] mem_rdata = 0, ins;
`ifdef FETCH_FAULT_EN
    logic        mem_fault = 0;
`endif

    int n_cmp = 0, n_err = 0;
    int lat = 0, wait_cnt = 0, n_ack = 0, n_idone = 0, ne = 0, first_ack_ne = -1, first_idone_ne = -1;
    fetch_entry_t sb[$];
    fetch_entry_t mon_e;
    logic [31:0] exp_addr = 0, last_pc = 32'h1, fault_addr = 32'hFFFF_FFFF;
    logic        stale = 0, ack_now, flt, saw_fault = 0;

    always #5 clk = ~clk;

    fetch_queue #(.RV(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
`ifdef FETCH_FAULT_EN
        .mem_fault(mem_fault),
`endif
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall), .ins(ins), .ins_pc(ins_pc),
        .idone(idone), .fetch_fault(fetch_fault)
    );

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        return a[16:1] ^ 16'h5A3C;
    endfunction

    // Issue monitor first, then flush on redirect, then memory response for the coming edge.
    always @(negedge clk) begin
        ne++;
        if (reset) begin
            mem_ack = 0; wait_cnt = 0; stale = 0; exp_addr = 0; sb.delete();
        end else begin
            if (idone) begin
                n_idone++;
                if (first_idone_ne < 0) first_idone_ne = ne;
                last_pc = ins_pc;
                if (fetch_fault) saw_fault = 1;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: got pc=%h ins=%h flt=%b, want no issue", ins_pc, ins, fetch_fault);
                end else begin
                    mon_e = sb.pop_front();
                    if ({ins_pc, ins, fetch_fault} !== {mon_e.pc, mon_e.ins, mon_e.fault}) begin
                        n_err++;
                        $display("FAIL issue: got pc=%h ins=%h flt=%b, want pc=%h ins=%h flt=%b",
                                 ins_pc, ins, fetch_fault, mon_e.pc, mon_e.ins, mon_e.fault);
                    end
                end
            end
            if (redirect) sb.delete();
            ack_now = 0;
            if (mem_ack) begin
                mem_ack = 0; wait_cnt = 0;
`ifdef FETCH_FAULT_EN
                mem_fault = 0;
`endif
            end else if (mem_req) begin
                if (wait_cnt >= lat) begin
                    ack_now = 1; mem_ack = 1; mem_rdata = mem_word(mem_addr); n_ack++;
                    if (first_ack_ne < 0) first_ack_ne = ne;
                    if (stale) stale = 0;
                    else if (!redirect) begin
                        n_cmp++;
                        if (mem_addr !== exp_addr) begin
                            n_err++;
                            $display("FAIL mem_addr: got %h want %h", mem_addr, exp_addr);
                        end
`ifdef FETCH_FAULT_EN
                        mem_fault = exp_addr == fault_addr;
                        flt = mem_fault;
`else
                        flt = 0;
`endif
                        sb.push_back('{pc: exp_addr, ins: flt ? FETCH_TRAP_INS : mem_word(exp_addr), fault: flt});
                        exp_addr += 2;
                    end
                end else wait_cnt++;
            end
            if (redirect && mem_req && !ack_now) stale = 1;
            if (redirect) exp_addr = redirect_pc & ~32'h1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; redirect = 0; n_ack = 0; n_idone = 0; first_ack_ne = -1; first_idone_ne = -1;
        cyc(2);
        reset = 0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect = 1; redirect_pc = pc;
        cyc(1);
        redirect = 0;
    endtask

    task automatic test_reset();
        #1 reset = 1;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_cmp++; if (idone !== 1'b0) begin n_err++; $display("FAIL reset_idone: got %b want 0", idone); end
        n_cmp++; if (fetch_fault !== 1'b0) begin n_err++; $display("FAIL reset_fetch_fault: got %b want 0", fetch_fault); end
        do_reset();
    endtask

    task automatic test_stream();
        cyc(40);
        n_cmp++;
        if (first_idone_ne - first_ack_ne != 1) begin
            n_err++; $display("FAIL stream_latency: got %0d want 1", first_idone_ne - first_ack_ne);
        end
        n_cmp++;
        if (n_idone < 15) begin n_err++; $display("FAIL stream_rate: got %0d issues want >=15", n_idone); end
    endtask

    task automatic test_stall_full();
        int base;
        bit found;
        stall = 1; lat = 0;
        do_reset();
        cyc(30);
        n_cmp++; if (n_ack != 4) begin n_err++; $display("FAIL full_acks: got %0d want 4", n_ack); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_mem_req: got %b want 0", mem_req); end
        stall = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (idone !== 1'b1) begin n_err++; $display("FAIL b2b_idone[%0d]: got %b want 1", i, idone); end
        end
        base = n_ack; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin cyc(1); found = n_ack > base; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL refetch: got no ack want one within 10 cycles"); end
    endtask

    task automatic test_redirect_discard();
        int base;
        bit found;
        stall = 0; lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin cyc(1); found = mem_req && mem_addr == 32'h8 && !mem_ack; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL discard_setup: got no req at 0x8 want one"); end
        redirect = 1; redirect_pc = 32'h100; #1;
        n_cmp++; if (idone !== 1'b0) begin n_err++; $display("FAIL discard_idone: got %b want 0", idone); end
        cyc(1); redirect = 0; #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_err++; $display("FAIL discard_hold: got req=%b addr=%h want req=1 addr=8", mem_req, mem_addr);
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin cyc(1); found = mem_req && mem_addr == 32'h100; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL discard_next_req: got addr=%h want 100", mem_addr); end
        base = n_idone; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin cyc(1); found = n_idone > base; end
        n_cmp++;
        if (!found || last_pc !== 32'h100) begin n_err++; $display("FAIL discard_first_issue: got pc=%h want 100", last_pc); end
    endtask

    task automatic test_redirect_ack_idone();
        bit found;
        stall = 1; lat = 0;
        do_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin cyc(1); found = sb.size() >= 2 && mem_req && !mem_ack; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL coincide_setup: got %0d entries want >=2 with req", sb.size()); end
        stall = 0; redirect = 1; redirect_pc = 32'h200; #1;
        n_cmp++; if (idone !== 1'b0) begin n_err++; $display("FAIL coincide_idone: got %b want 0", idone); end
        @(negedge clk); #1;
        n_cmp++; if (mem_ack !== 1'b1) begin n_err++; $display("FAIL coincide_ack: got %b want 1", mem_ack); end
        cyc(1); redirect = 0; #1;
        n_cmp++;
        if (idone !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL coincide_flush: got idone=%b req=%b want 0 0", idone, mem_req);
        end
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin cyc(1); found = mem_req; end
        n_cmp++;
        if (!found || mem_addr !== 32'h200) begin n_err++; $display("FAIL coincide_next_req: got req=%b addr=%h want 1 200", mem_req, mem_addr); end
    endtask

    task automatic test_wrap();
        bit found;
        stall = 0; lat = 0;
        do_reset();
        last_pc = 32'h1;
        do_redirect(32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin cyc(1); found = mem_req && mem_addr == 32'h0; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL wrap_addr: got addr=%h want 0", mem_addr); end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin cyc(1); found = last_pc == 32'h0; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL wrap_issue: got last pc=%h want 0", last_pc); end
    endtask

    task automatic test_reset_mid();
        bit found;
        stall = 0; lat = 6;
        do_reset();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin cyc(1); found = mem_req; end
        reset = 1; #1;
        n_cmp++; if (!found || mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mid: got req=%b want 0", mem_req); end
        cyc(1); reset = 0; lat = 0;
    endtask

`ifdef FETCH_FAULT_EN
    task automatic test_fault();
        bit found;
        int reqs;
        stall = 0; lat = 0;
        do_reset();
        fault_addr = 32'h20; saw_fault = 0;
        do_redirect(32'h20);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin cyc(1); found = saw_fault; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL fault_issue: got fetch_fault=0 want 1"); end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin cyc(1); reqs += int'(mem_req); end
        n_cmp++; if (reqs != 0) begin n_err++; $display("FAIL fault_halt: got %0d req cycles want 0", reqs); end
        fault_addr = 32'hFFFF_FFFF;
        do_redirect(32'h40);
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin cyc(1); found = mem_req && mem_addr == 32'h40; end
        n_cmp++; if (!found) begin n_err++; $display("FAIL fault_exit: got addr=%h want 40", mem_addr); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall_full();
        test_redirect_discard();
        test_redirect_ack_idone();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_FAULT_EN
        test_fault();
`endif
        cyc(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
